// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared constants for the FIFO-draining UART transmitter: FSM encoding,
// default frame and baud settings, and a divisor helper.
package uart_tx_fifo_drain_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int DEF_B       = 8;
  localparam int DEF_OVS     = 16;
  localparam int DEF_SB_TICK = 16;
  localparam int DEF_DVSR    = 163;
  localparam int DEF_DVSR_W  = 8;

  // Rounded to nearest, so 50 MHz at 19200 baud x16 gives 163.
  function automatic int unsigned calc_dvsr(input int unsigned clk_hz,
                                            input int unsigned baud,
                                            input int unsigned ovs);
    int unsigned den;
    den = baud * ovs;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_baud_gen.sv
// Mod-DVSR baud tick generator; s_tick is a one-clock pulse every DVSR clocks.
// A synchronous clear restarts the count so a new frame starts on a full bit period.
module uart_tx_fifo_drain_baud_gen #(
  parameter int DVSR   = 163,
  parameter int DVSR_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic s_tick
);

  logic [DVSR_W-1:0] cnt_q, cnt_d;

  assign s_tick = (cnt_q == DVSR_W'(DVSR - 1));

  always_comb begin
    cnt_d = cnt_q + DVSR_W'(1);
    if (clr || s_tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops one word per frame from a FWFT FIFO and sends it as start/B data/stop on tx.
// Frame takes (1+B)*OVS*DVSR + SB_TICK*DVSR clocks; FIFO is only read while idle.
module uart_tx_fifo_drain
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int B       = DEF_B,
  parameter int OVS     = DEF_OVS,
  parameter int SB_TICK = DEF_SB_TICK,
  parameter int DVSR    = DEF_DVSR,
  parameter int DVSR_W  = DEF_DVSR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fifo_empty,
  input  logic [B-1:0] fifo_data,
  output logic         fifo_rd,
  output logic         tx,
  output logic         tx_busy,
  output logic         tx_done_tick
);

  localparam int S_MAX = (SB_TICK > OVS) ? SB_TICK : OVS;
  localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int N_W   = (B > 1) ? $clog2(B) : 1;

  logic [1:0]     state_q, state_d;
  logic [S_W-1:0] s_q, s_d;
  logic [N_W-1:0] n_q, n_d;
  logic [B-1:0]   shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           s_tick, baud_clr;
  logic           bit_end, stop_end, last_bit;

  uart_tx_fifo_drain_baud_gen #(
    .DVSR   (DVSR),
    .DVSR_W (DVSR_W)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clr    (baud_clr),
    .s_tick (s_tick)
  );

  assign bit_end  = s_tick && (s_q == S_W'(OVS - 1));
  assign stop_end = s_tick && (s_q == S_W'(SB_TICK - 1));
  assign last_bit = (n_q == N_W'(B - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty)          state_d = ST_START;
      ST_START: if (bit_end)              state_d = ST_DATA;
      ST_DATA:  if (bit_end && last_bit)  state_d = ST_STOP;
      ST_STOP:  if (stop_end)             state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd      = 1'b0;
    baud_clr     = 1'b0;
    tx_done_tick = 1'b0;
    tx_d         = tx_q;
    shift_d      = shift_q;
    s_d          = s_q;
    n_d          = n_q;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_rd  = 1'b1;
          baud_clr = 1'b1;
          shift_d  = fifo_data;
          tx_d     = 1'b0;
          s_d      = '0;
          n_d      = '0;
        end
      end
      ST_START: begin
        if (s_tick) s_d = s_q + S_W'(1);
        if (bit_end) begin
          s_d  = '0;
          tx_d = shift_q[0];
        end
      end
      ST_DATA: begin
        if (s_tick) s_d = s_q + S_W'(1);
        if (bit_end) begin
          s_d = '0;
          if (last_bit) begin
            tx_d = 1'b1;
          end else begin
            // Shift first so the next bit is driven on the same edge.
            n_d     = n_q + N_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end
      ST_STOP: begin
        if (s_tick) s_d = s_q + S_W'(1);
        if (stop_end) begin
          s_d          = '0;
          tx_done_tick = 1'b1;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: frame-level reference model plus vector table
// and hand-written sequences for back-to-back, reset and gated-FIFO cases.
module tb_uart_tx_fifo_drain;

  localparam int B     = 8;
  localparam int OVS   = 16;
  localparam int DV    = 4;
  localparam int SB0   = 16;
  localparam int SB1   = 32;
  localparam int BIT   = OVS * DV;
  localparam int FL0   = (1 + B) * BIT + SB0 * DV;
  localparam int FL1   = (1 + B) * BIT + SB1 * DV;

  logic         clk;
  logic         reset;
  logic         fifo_empty [2];
  logic [B-1:0] fifo_data  [2];
  logic         fifo_rd    [2];
  logic         tx         [2];
  logic         tx_busy    [2];
  logic         tx_done_tick [2];

  uart_tx_fifo_drain #(.B(B), .OVS(OVS), .SB_TICK(SB0), .DVSR(DV), .DVSR_W(3)) u0 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
    .fifo_rd(fifo_rd[0]), .tx(tx[0]), .tx_busy(tx_busy[0]), .tx_done_tick(tx_done_tick[0])
  );

  uart_tx_fifo_drain #(.B(B), .OVS(OVS), .SB_TICK(SB1), .DVSR(DV), .DVSR_W(3)) u1 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
    .fifo_rd(fifo_rd[1]), .tx(tx[1]), .tx_busy(tx_busy[1]), .tx_done_tick(tx_done_tick[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       gate    [2];
  logic       rd_pend [2];
  int         ph      [2];
  logic [7:0] cur     [2];
  int         pops    [2];
  int         ph_s    [2];
  logic       tx_s    [2];
  logic       rd_s    [2];
  logic       done_s  [2];
  int         smp;
  int         checks;
  int         failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int frame_len(input int d);
    return (d == 0) ? FL0 : FL1;
  endfunction

  // Line level expected p clocks into a frame: start slot, data slots LSB first, then stop.
  function automatic logic exp_tx(input int p, input logic [7:0] w);
    int slot;
    slot = (p - 1) / BIT;
    if (slot == 0) return 1'b0;
    if (slot <= B) return w[slot-1];
    return 1'b1;
  endfunction

  task automatic drive_inputs();
    int sz;
    for (int d = 0; d < 2; d++) begin
      sz = (d == 0) ? q0.size() : q1.size();
      fifo_empty[d] = gate[d] || (sz == 0);
      if (fifo_empty[d])  fifo_data[d] = 8'($urandom);
      else if (d == 0)    fifo_data[d] = q0[0];
      else                fifo_data[d] = q1[0];
    end
  endtask

  task automatic step();
    logic e_tx, e_rd, e_busy, e_done;
    @(posedge clk);
    #1;
    if (rd_pend[0] && q0.size() > 0) void'(q0.pop_front());
    if (rd_pend[1] && q1.size() > 0) void'(q1.pop_front());
    rd_pend[0] = 1'b0;
    rd_pend[1] = 1'b0;
    drive_inputs();
    @(negedge clk);
    smp++;
    for (int d = 0; d < 2; d++) begin
      if (ph[d] == 0) begin
        e_tx = 1'b1; e_rd = !fifo_empty[d]; e_busy = 1'b0; e_done = 1'b0;
      end else begin
        e_tx = exp_tx(ph[d], cur[d]); e_rd = 1'b0; e_busy = 1'b1;
        e_done = (ph[d] == frame_len(d));
      end
      check($sformatf("u%0d {tx,rd,busy,done} sample %0d", d, smp),
            {28'd0, tx[d], fifo_rd[d], tx_busy[d], tx_done_tick[d]},
            {28'd0, e_tx, e_rd, e_busy, e_done});
      ph_s[d]   = ph[d];
      tx_s[d]   = tx[d];
      rd_s[d]   = fifo_rd[d];
      done_s[d] = tx_done_tick[d];
      if (fifo_rd[d]) begin
        pops[d]++;
        rd_pend[d] = 1'b1;
      end
      if (ph[d] == 0) begin
        if (!fifo_empty[d]) begin
          ph[d]  = 1;
          cur[d] = fifo_data[d];
        end
      end else begin
        ph[d] = (ph[d] == frame_len(d)) ? 0 : ph[d] + 1;
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int d = 0; d < 2; d++)
      check($sformatf("%s u%0d {tx,busy,rd,done}", tag, d),
            {28'd0, tx[d], tx_busy[d], fifo_rd[d], tx_done_tick[d]}, 32'h8);
  endtask

  task automatic run_frame(input int d, input int budget, output logic [9:0] bits,
                           output int len, output int npop, output int ndone, output int zeros);
    int rd_at, done_at, p0, p, slot;
    bits = '0; len = -1; rd_at = -1; done_at = -1; p0 = pops[d]; ndone = 0; zeros = 0;
    for (int c = 0; c < budget; c++) begin
      step();
      p = ph_s[d];
      if (rd_s[d] && rd_at < 0) rd_at = smp;
      if (p >= 1 && p <= BIT && tx_s[d] == 1'b0) zeros++;
      if (p >= BIT / 2 && ((p - BIT / 2) % BIT) == 0) begin
        slot = (p - BIT / 2) / BIT;
        if (slot < 10) bits[slot] = tx_s[d];
      end
      if (done_s[d]) begin
        ndone++;
        done_at = smp;
      end
      if (done_at >= 0 && p == 0) break;
    end
    npop = pops[d] - p0;
    if (rd_at >= 0 && done_at >= 0) len = done_at - rd_at;
  endtask

  typedef struct {
    int         sel;
    logic [7:0] word;
    logic [9:0] slots;
    int         len;
  } vec_t;

  vec_t tbl[3];

  initial begin
    logic [9:0] bits;
    int len, npop, ndone, zeros;
    int nrd, nd, rd2, d1, ones, base;
    logic gap_tx;
    bit reached;

    tbl[0] = '{sel: 0, word: 8'hA5, slots: 10'b1101001010, len: 640};
    tbl[1] = '{sel: 1, word: 8'h3C, slots: 10'b1001111000, len: 704};
    tbl[2] = '{sel: 0, word: 8'h01, slots: 10'b1000000010, len: 640};

    checks = 0; failures = 0; smp = 0;
    for (int d = 0; d < 2; d++) begin
      gate[d] = 1'b0; rd_pend[d] = 1'b0; ph[d] = 0; cur[d] = '0; pops[d] = 0;
      fifo_empty[d] = 1'b1; fifo_data[d] = '0;
    end
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 chk_reset("reset_async");
    repeat (3) begin
      @(negedge clk);
      chk_reset("reset_held");
    end
    reset = 1'b0;

    // Idle line with empty FIFO
    repeat (1000) step();
    check("idle_no_pops", 32'(pops[0] + pops[1]), 32'd0);

    for (int i = 0; i < 3; i++) begin
      if (tbl[i].sel == 0) q0.push_back(tbl[i].word);
      else                 q1.push_back(tbl[i].word);
      run_frame(tbl[i].sel, 2000, bits, len, npop, ndone, zeros);
      check($sformatf("tbl%0d slot levels", i), 32'(bits), 32'(tbl[i].slots));
      check($sformatf("tbl%0d rd-to-done clocks", i), 32'(len), 32'(tbl[i].len));
      check($sformatf("tbl%0d pop count", i), 32'(npop), 32'd1);
      check($sformatf("tbl%0d done count", i), 32'(ndone), 32'd1);
      repeat (3) step();
    end

    // Back-to-back frames with the FIFO kept non-empty
    q0.push_back(8'h00);
    q0.push_back(8'hFF);
    nrd = 0; nd = 0; rd2 = -1; d1 = -1; ones = 0; gap_tx = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (rd_s[0]) begin
        nrd++;
        if (nrd == 2) begin
          rd2 = smp;
          gap_tx = tx_s[0];
        end
      end
      if (done_s[0]) begin
        nd++;
        if (nd == 1) d1 = smp;
      end
      if (nrd == 2 && ph_s[0] >= BIT + BIT / 2 && ph_s[0] <= 9 * BIT &&
          ((ph_s[0] - BIT / 2) % BIT) == 0)
        ones += int'(tx_s[0]);
      if (nd == 2 && ph_s[0] == 0) break;
    end
    check("b2b second rd after first done", 32'(rd2 - d1), 32'd1);
    check("b2b gap line level", {31'd0, gap_tx}, 32'd1);
    check("b2b second frame ones", 32'(ones), 32'd8);
    check("b2b pops", 32'(nrd), 32'd2);
    check("b2b dones", 32'(nd), 32'd2);
    repeat (3) step();

    // Reset in the middle of data bit 3, then a fresh word
    q0.push_back(8'h55);
    reached = 1'b0;
    for (int c = 0; c < 700; c++) begin
      step();
      if (ph_s[0] == 4 * BIT + 21) begin
        reached = 1'b1;
        break;
      end
    end
    check("midframe bit3 reached", {31'd0, reached}, 32'd1);
    #2 reset = 1'b1;
    #1 chk_reset("midframe_reset_async");
    ph[0] = 0; ph[1] = 0; rd_pend[0] = 1'b0; rd_pend[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_reset("midframe_reset_held");
    end
    reset = 1'b0;
    q0.push_back(8'h81);
    run_frame(0, 2000, bits, len, npop, ndone, zeros);
    check("after_reset slot levels", 32'(bits), 32'(10'b1100000010));
    check("after_reset start bit clocks", 32'(zeros), 32'd64);
    check("after_reset rd-to-done clocks", 32'(len), 32'd640);
    check("after_reset pop count", 32'(npop), 32'd1);

    // Three random words with the empty flag toggling at random
    for (int i = 0; i < 3; i++) q0.push_back(8'($urandom));
    base = pops[0]; nd = 0;
    for (int c = 0; c < 8000; c++) begin
      gate[0] = 1'($urandom_range(0, 1));
      step();
      if (done_s[0]) nd++;
      if (pops[0] - base == 3 && nd == 3 && ph_s[0] == 0) break;
    end
    gate[0] = 1'b0;
    check("gated pop count", 32'(pops[0] - base), 32'd3);
    check("gated done count", 32'(nd), 32'd3);
    check("gated fifo drained", 32'(q0.size()), 32'd0);
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
Serial UART transmitter that acts as the read side of the team's FIFO. It pulls words from a first-word-fall-through FIFO interface (empty, rd, r_data) and shifts each word out as an 8N1-style frame on a single tx line. It contains its own baud-tick generator and sits between the FIFO's read port and the device pin.

Parameters:
B, 8, data bits per frame (sent LSB first); must match the FIFO word width
OVS, 16, baud ticks per start bit and per data bit
SB_TICK, 16, baud ticks in the stop period (16 gives 1 stop bit, 24 gives 1.5, 32 gives 2)
DVSR, 163, clocks per baud tick (e.g. 50 MHz / (19200*16))
DVSR_W, 8, width of the baud counter; must satisfy 2**DVSR_W >= DVSR

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
fifo_empty  in  1  FIFO empty flag; fifo_data is valid whenever it is low
fifo_data  in  B  FIFO head word (first-word-fall-through)
fifo_rd  out  1  pop strobe, one clock wide
tx  out  1  serial line output, idle high, registered
tx_busy  out  1  high whenever state != IDLE
tx_done_tick  out  1  one-clock pulse when the stop period completes

Behaviour:
- Clock/reset: one clock domain. Reset is asynchronous and active-high. All registers clear on reset.
- Reset values: state=IDLE, tx=1, tx_busy=0, fifo_rd=0, tx_done_tick=0, baud counter=0, tick count=0, bit index=0, shift register=0.
- Baud generator: counts 0..DVSR-1. s_tick=1 when count==DVSR-1, then wraps to 0. The counter is synchronously cleared on the cycle the FSM leaves IDLE, so every bit period is exactly OVS*DVSR clocks.
- FSM states:
  - IDLE -> START when fifo_empty=0.
  - START -> DATA after OVS ticks.
  - DATA -> STOP after B bits, each lasting OVS ticks.
  - STOP -> IDLE after SB_TICK ticks.
- Tick count s: 0..OVS-1 in START/DATA, 0..SB_TICK-1 in STOP. It advances only on s_tick and resets to 0 on every state or bit change.
- Accept (IDLE with fifo_empty=0), all in the same cycle:
  - fifo_rd=1 (combinational: state==IDLE & ~fifo_empty).
  - fifo_data latched into the shift register.
  - tx_next=0.
  - The state enters START on the next edge.
- Pop rule: fifo_rd is never asserted while fifo_empty=1 or outside IDLE. Exactly one pop per frame.
- tx is registered. Every transition of tx happens on the same edge as the state/bit change:
  - start bit = 0 for OVS*DVSR clocks;
  - then shift[0] for each bit, shifting right after each bit;
  - stop = 1 for SB_TICK*DVSR clocks.
- tx_done_tick is combinational. It is high in the STOP cycle where s_tick=1 and s==SB_TICK-1.
- Back-to-back frames: IDLE is occupied for at least one clock, so the minimum inter-frame gap is 1 clock of tx=1. The next fifo_rd comes exactly 1 clock after tx_done_tick if the FIFO is non-empty.
- Frame length, from the edge after fifo_rd to the edge back in IDLE: (1+B)*OVS*DVSR + SB_TICK*DVSR clocks.
- fifo_empty and fifo_data are ignored outside IDLE.
- Reset mid-frame: tx goes to 1 immediately and asynchronously, and the FSM returns to IDLE. The popped word is lost and is not retransmitted.

Decomposition:
- Shared package:
  - FSM state encoding localparams (IDLE, START, DATA, STOP; 2 bits);
  - default DVSR/OVS/SB_TICK constants;
  - a function computing DVSR from clock frequency and baud rate.
- One sub-module, baud_gen: mod-DVSR counter with synchronous clear, output s_tick.

Test Plan:
Bench parameters unless noted: DVSR=4, OVS=16, SB_TICK=16, B=8, so one bit = 64 clocks and a frame = 640 clocks.
1. Reset asserted, then released with fifo_empty=1 held for 1000 clocks -> tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0 throughout.
2. One word 0xA5 (fifo_empty drops for 1 clock, rises after the pop) -> single fifo_rd pulse; tx sequence is:
   - 0 for 64 clocks;
   - 1,0,1,0,0,1,0,1, each for 64 clocks;
   - 1 for 64 clocks;
   - tx_done_tick pulses once, 640 clocks after the edge following fifo_rd.
3. Words 0x00 then 0xFF with the FIFO held non-empty -> second fifo_rd exactly 1 clock after the first tx_done_tick; a 1-clock high gap between frames; second frame data bits all 1.
4. SB_TICK=32 with word 0x3C -> stop period of 128 clocks; frame length 704 clocks; done pulse at the end of the stop period.
5. Reset asserted mid data bit 3 of 0x55 -> tx=1 and tx_busy=0 asynchronously. After release with a new word 0x81 available, a fresh full-length 64-clock start bit precedes 0x81, and there is no residue of 0x55.
6. Sample fifo_rd at every cycle across 3 frames with the FIFO toggling empty mid-frame -> exactly 3 pulses, each only while state==IDLE and fifo_empty=0.
